// File: rtl/board_generator.sv
// Minesweeper board generator: clears the board, then places distinct LFSR-chosen mines.
// Optional safe-cell exclusion is enabled by defining BOARDGEN_SAFE_CELL_EN.
module board_generator #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int CELLS         = 25,
  parameter int NUM_MINES     = 5,
  parameter int MINE_CODE     = 10,
  parameter int EMPTY_CODE    = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              seed,
  input  logic [ADDRESS_WIDTH-1:0] safe_cell,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     wEn,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(CELLS):0]   mines_placed
);

  localparam int IDXW = $clog2(CELLS);
  localparam logic [IDXW:0]   NCELL = (IDXW+1)'(CELLS);
  localparam logic [IDXW:0]   NMINE = (IDXW+1)'(NUM_MINES);
  localparam logic [IDXW-1:0] LAST  = IDXW'(CELLS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PICK, PROBE, PLACE, FIN
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_nxt;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] pick;
  logic [IDXW:0]   cnt;
  logic            bad_safe;
  logic            reject;

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign pick     = lfsr_nxt[IDXW-1:0];

`ifdef BOARDGEN_SAFE_CELL_EN
  logic [ADDRESS_WIDTH-1:0] safe_q;

  // Remember the protected cell for the whole generation run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      safe_q <= '0;
    else if (state == IDLE && start)
      safe_q <= safe_cell;
  end

  assign bad_safe = (ADDRESS_WIDTH'(pick) == safe_q);
`else
  logic unused_safe;
  assign unused_safe = ^safe_cell;
  assign bad_safe    = 1'b0;
`endif

  assign reject = ({1'b0, pick} >= NCELL) || bad_safe;

  // Main sequencer: clear pass, then pick/probe/place loop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= 16'hACE1;
      idx   <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lfsr  <= (seed == '0) ? 16'hACE1 : seed;
            cnt   <= '0;
            idx   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST)
            state <= PICK;
        end
        PICK: begin
          lfsr <= lfsr_nxt;
          if (!reject) begin
            cand  <= pick;
            state <= PROBE;
          end
        end
        PROBE: begin
          if (rdata == DATA_WIDTH'(MINE_CODE))
            state <= PICK;
          else
            state <= PLACE;
        end
        PLACE: begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == NMINE)
            state <= FIN;
          else
            state <= PICK;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port decoded from registered state so it is stable all cycle
  always_comb begin
    wEn    = 1'b0;
    addr   = '0;
    dataIn = '0;
    unique case (state)
      CLEAR: begin
        wEn    = 1'b1;
        addr   = ADDRESS_WIDTH'(idx);
        dataIn = DATA_WIDTH'(EMPTY_CODE);
      end
      PROBE: begin
        addr = ADDRESS_WIDTH'(cand);
      end
      PLACE: begin
        wEn    = 1'b1;
        addr   = ADDRESS_WIDTH'(cand);
        dataIn = DATA_WIDTH'(MINE_CODE);
      end
      default: begin
        wEn    = 1'b0;
      end
    endcase
  end

  assign busy         = (state == CLEAR) || (state == PICK) ||
                        (state == PROBE) || (state == PLACE);
  assign done         = (state == FIN);
  assign mines_placed = cnt;

endmodule
